// File: rtl/mem_port_scheduler.sv
// rtl/mem_port_scheduler.sv - single-port memory scheduler for load and store ports
module mem_port_scheduler #(
   parameter int LOAD_COUNT   = 2,
   parameter int STORE_COUNT  = 2,
   parameter int ADDRESS_SIZE = 32,
   parameter int DATA_SIZE    = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [LOAD_COUNT-1:0]               ld_valid,
   input  logic [LOAD_COUNT*ADDRESS_SIZE-1:0]  ld_addr,
   output logic [LOAD_COUNT-1:0]               ld_ready,
   output logic [LOAD_COUNT-1:0]               ld_data_valid,
   output logic [LOAD_COUNT*DATA_SIZE-1:0]     ld_data,
   input  logic [LOAD_COUNT-1:0]               ld_data_ready,
   input  logic [STORE_COUNT-1:0]              st_valid,
   input  logic [STORE_COUNT*ADDRESS_SIZE-1:0] st_addr,
   input  logic [STORE_COUNT*DATA_SIZE-1:0]    st_data,
   output logic [STORE_COUNT-1:0]              st_ready,
   output logic                                mem_en,
   output logic                                mem_we,
   output logic [ADDRESS_SIZE-1:0]             mem_addr,
   output logic [DATA_SIZE-1:0]                mem_wdata,
   input  logic [DATA_SIZE-1:0]                mem_rdata,
   output logic                                idle
);

   localparam int LW = (LOAD_COUNT  > 1) ? $clog2(LOAD_COUNT)  : 1;
   localparam int SW = (STORE_COUNT > 1) ? $clog2(STORE_COUNT) : 1;
   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   logic [LOAD_COUNT-1:0] inflight;
   logic [LOAD_COUNT-1:0] slot_full;
   logic [DATA_SIZE-1:0]  slot_data [LOAD_COUNT];
   logic [LW-1:0]         ld_ptr;
   logic [SW-1:0]         st_ptr;
   logic [7:0]            starve_cnt;

   logic [LOAD_COUNT-1:0] ld_elig;
   logic                  ld_any;
   logic                  st_any;
   logic                  force_st;
   logic                  grant_ld;
   logic                  grant_st;
   logic [LW-1:0]         ld_pick;
   logic [LW-1:0]         ld_idx;
   logic [SW-1:0]         st_pick;
   logic [SW-1:0]         st_idx;

   // A port with a full slot or a read in flight is held off, even if its slot drains this cycle
   assign ld_elig  = ld_valid & ~slot_full & ~inflight;
   assign ld_any   = |ld_elig;
   assign st_any   = |st_valid;
   assign force_st = (starve_cnt == LIMIT) && st_any;

   // Nothing is granted while reset is held so every output stays at zero
   assign grant_st = rst && st_any && (force_st || !ld_any);
   assign grant_ld = rst && ld_any && !force_st;

   // Load round-robin: walk backwards so the nearest port after the pointer is the final pick
   always_comb begin
      ld_pick = '0;
      ld_idx  = '0;
      for (int k = LOAD_COUNT; k >= 1; k--) begin
         ld_idx = LW'((int'(ld_ptr) + k) % LOAD_COUNT);
         if (ld_elig[ld_idx]) ld_pick = ld_idx;
      end
   end

   // Store round-robin, same search order as the loads
   always_comb begin
      st_pick = '0;
      st_idx  = '0;
      for (int k = STORE_COUNT; k >= 1; k--) begin
         st_idx = SW'((int'(st_ptr) + k) % STORE_COUNT);
         if (st_valid[st_idx]) st_pick = st_idx;
      end
   end

   // Drive the single memory port and the one-hot grant for the winning class
   always_comb begin
      ld_ready  = '0;
      st_ready  = '0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (grant_ld) begin
         ld_ready[ld_pick] = 1'b1;
         mem_en            = 1'b1;
         mem_addr          = ld_addr[int'(ld_pick)*ADDRESS_SIZE +: ADDRESS_SIZE];
      end else if (grant_st) begin
         st_ready[st_pick] = 1'b1;
         mem_en            = 1'b1;
         mem_we            = 1'b1;
         mem_addr          = st_addr[int'(st_pick)*ADDRESS_SIZE +: ADDRESS_SIZE];
         mem_wdata         = st_data[int'(st_pick)*DATA_SIZE +: DATA_SIZE];
      end
   end

   for (genvar g = 0; g < LOAD_COUNT; g++) begin : g_slot_out
      assign ld_data[g*DATA_SIZE +: DATA_SIZE] = slot_data[g];
   end

   assign ld_data_valid = slot_full;
   assign idle          = !(|ld_valid) && !(|st_valid) && !(|inflight) && !(|slot_full);

   // Scheduler state: pointers, starvation count, in-flight reads and response slots
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ld_ptr     <= LW'(LOAD_COUNT - 1);
         st_ptr     <= SW'(STORE_COUNT - 1);
         starve_cnt <= '0;
         inflight   <= '0;
         slot_full  <= '0;
         for (int i = 0; i < LOAD_COUNT; i++) slot_data[i] <= '0;
      end else begin
         if (grant_ld) ld_ptr <= ld_pick;
         if (grant_st) st_ptr <= st_pick;

         if (grant_st) begin
            starve_cnt <= '0;
         end else if (st_any && grant_ld && (starve_cnt < LIMIT)) begin
            starve_cnt <= starve_cnt + 8'd1;
         end

         // A read is in flight for exactly one cycle; its data lands in the slot the cycle after
         for (int i = 0; i < LOAD_COUNT; i++) begin
            if (inflight[i]) begin
               slot_full[i] <= 1'b1;
               slot_data[i] <= mem_rdata;
            end else if (slot_full[i] && ld_data_ready[i]) begin
               slot_full[i] <= 1'b0;
            end
         end
         inflight <= ld_ready;
      end
   end

endmodule

// File: tb/tb_mem_port_scheduler.sv
// tb/tb_mem_port_scheduler.sv - self-checking bench for mem_port_scheduler
module tb_mem_port_scheduler;

   localparam int LC = 4;
   localparam int SC = 2;
   localparam int AS = 32;
   localparam int DS = 32;
   localparam int SL = 4;

   logic              clk;
   logic              rst;
   logic [LC-1:0]     ld_valid;
   logic [LC*AS-1:0]  ld_addr;
   logic [LC-1:0]     ld_ready;
   logic [LC-1:0]     ld_data_valid;
   logic [LC*DS-1:0]  ld_data;
   logic [LC-1:0]     ld_data_ready;
   logic [SC-1:0]     st_valid;
   logic [SC*AS-1:0]  st_addr;
   logic [SC*DS-1:0]  st_data;
   logic [SC-1:0]     st_ready;
   logic              mem_en;
   logic              mem_we;
   logic [AS-1:0]     mem_addr;
   logic [DS-1:0]     mem_wdata;
   logic [DS-1:0]     mem_rdata;
   logic              idle;

   mem_port_scheduler #(
      .LOAD_COUNT(LC), .STORE_COUNT(SC), .ADDRESS_SIZE(AS), .DATA_SIZE(DS), .STARVE_LIMIT(SL)
   ) dut (
      .clk(clk), .rst(rst),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ready(ld_ready),
      .ld_data_valid(ld_data_valid), .ld_data(ld_data), .ld_data_ready(ld_data_ready),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .idle(idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: per-port slot contents, in-flight flags, last winners, starvation count
   logic [LC-1:0] m_full;
   logic [LC-1:0] m_infl;
   logic [DS-1:0] m_data [LC];
   int            m_ldptr;
   int            m_stptr;
   int            m_starve;
   int            e_lp;
   int            e_sp;

   typedef struct {
      logic [LC-1:0] lv;
      logic [SC-1:0] sv;
      logic [LC-1:0] ldr;
      logic [DS-1:0] rdata;
      logic [LC-1:0] e_lr;
      logic [SC-1:0] e_sr;
      logic          e_we;
      logic [AS-1:0] e_addr;
      logic [DS-1:0] e_wdata;
      logic [LC-1:0] e_ldv;
      logic [DS-1:0] e_d0;
      logic          e_idle;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_full   = '0;
      m_infl   = '0;
      for (int i = 0; i < LC; i++) m_data[i] = '0;
      m_ldptr  = LC - 1;
      m_stptr  = SC - 1;
      m_starve = 0;
   endtask

   // Decide the winner from the class rules: forced store, else loads, else stores
   task automatic model_eval();
      logic [LC-1:0] le;
      le   = ld_valid & ~m_full & ~m_infl;
      e_lp = -1;
      e_sp = -1;
      if ((st_valid != 0) && ((m_starve == SL) || (le == 0))) begin
         for (int k = 1; k <= SC; k++)
            if (e_sp < 0 && st_valid[(m_stptr + k) % SC]) e_sp = (m_stptr + k) % SC;
      end else if (le != 0) begin
         for (int k = 1; k <= LC; k++)
            if (e_lp < 0 && le[(m_ldptr + k) % LC]) e_lp = (m_ldptr + k) % LC;
      end
   endtask

   task automatic model_check();
      logic [LC-1:0] elr;
      logic [SC-1:0] esr;
      logic [AS-1:0] ea;
      logic [DS-1:0] ew;
      logic          eidle;
      elr = '0; esr = '0; ea = '0; ew = '0;
      if (e_lp >= 0) begin
         elr[e_lp] = 1'b1;
         ea = ld_addr[e_lp*AS +: AS];
      end
      if (e_sp >= 0) begin
         esr[e_sp] = 1'b1;
         ea = st_addr[e_sp*AS +: AS];
         ew = st_data[e_sp*DS +: DS];
      end
      eidle = (ld_valid == 0) && (st_valid == 0) && (m_infl == 0) && (m_full == 0);
      chk("m_ld_ready", 128'(ld_ready), 128'(elr));
      chk("m_st_ready", 128'(st_ready), 128'(esr));
      chk("m_mem_bus", 128'({mem_en, mem_we, mem_addr, mem_wdata}),
          128'({(e_lp >= 0) || (e_sp >= 0), e_sp >= 0, ea, ew}));
      chk("m_ld_data_valid", 128'(ld_data_valid), 128'(m_full));
      chk("m_idle", 128'(idle), 128'(eidle));
      for (int i = 0; i < LC; i++)
         if (m_full[i]) chk($sformatf("m_ld_data%0d", i), 128'(ld_data[i*DS +: DS]), 128'(m_data[i]));
   endtask

   task automatic model_clock();
      for (int i = 0; i < LC; i++) begin
         if (m_infl[i]) begin
            m_full[i] = 1'b1;
            m_data[i] = mem_rdata;
            m_infl[i] = 1'b0;
         end else if (m_full[i] && ld_data_ready[i]) begin
            m_full[i] = 1'b0;
         end
      end
      if (e_lp >= 0) begin
         m_infl[e_lp] = 1'b1;
         m_ldptr = e_lp;
         if (st_valid != 0 && m_starve < SL) m_starve++;
      end
      if (e_sp >= 0) begin
         m_stptr  = e_sp;
         m_starve = 0;
      end
   endtask

   task automatic half();
      @(negedge clk);
      model_eval();
      model_check();
   endtask

   task automatic finish_cycle();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic step();
      half();
      finish_cycle();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      ld_valid = '0; st_valid = '0; ld_data_ready = '0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic fixed_addrs();
      ld_addr = {32'h40, 32'h30, 32'h20, 32'h10};
      st_addr = {32'h210, 32'h200};
      st_data = {32'hD1, 32'hD0};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1;
      logic [DS-1:0] held, rd_c1;
      logic stable;

      // lv, sv, ldr, rdata | ld_ready, st_ready, we, addr, wdata, ld_data_valid, ld_data[0], idle
      tbl[0]  = '{4'b0001, 2'b00, 4'b1111, 32'h0,  4'b0001, 2'b00, 1'b0, 32'h10,  32'h0,  4'b0000, 32'h0,  1'b0};
      tbl[1]  = '{4'b0001, 2'b00, 4'b1111, 32'hAB, 4'b0000, 2'b00, 1'b0, 32'h0,   32'h0,  4'b0000, 32'h0,  1'b0};
      tbl[2]  = '{4'b0000, 2'b00, 4'b0000, 32'h0,  4'b0000, 2'b00, 1'b0, 32'h0,   32'h0,  4'b0001, 32'hAB, 1'b0};
      tbl[3]  = '{4'b0001, 2'b00, 4'b0001, 32'h0,  4'b0000, 2'b00, 1'b0, 32'h0,   32'h0,  4'b0001, 32'hAB, 1'b0};
      tbl[4]  = '{4'b0001, 2'b00, 4'b1111, 32'h0,  4'b0001, 2'b00, 1'b0, 32'h10,  32'h0,  4'b0000, 32'h0,  1'b0};
      tbl[5]  = '{4'b0000, 2'b11, 4'b1111, 32'h5C, 4'b0000, 2'b01, 1'b1, 32'h200, 32'hD0, 4'b0000, 32'h0,  1'b0};
      tbl[6]  = '{4'b0000, 2'b11, 4'b1111, 32'h0,  4'b0000, 2'b10, 1'b1, 32'h210, 32'hD1, 4'b0001, 32'h5C, 1'b0};
      tbl[7]  = '{4'b0000, 2'b11, 4'b1111, 32'h0,  4'b0000, 2'b01, 1'b1, 32'h200, 32'hD0, 4'b0000, 32'h0,  1'b0};
      tbl[8]  = '{4'b0011, 2'b01, 4'b0000, 32'h0,  4'b0010, 2'b00, 1'b0, 32'h20,  32'h0,  4'b0000, 32'h0,  1'b0};
      tbl[9]  = '{4'b0011, 2'b01, 4'b0000, 32'h0,  4'b0001, 2'b00, 1'b0, 32'h10,  32'h0,  4'b0000, 32'h0,  1'b0};
      tbl[10] = '{4'b0011, 2'b00, 4'b0000, 32'h77, 4'b0000, 2'b00, 1'b0, 32'h0,   32'h0,  4'b0010, 32'h0,  1'b0};
      tbl[11] = '{4'b0000, 2'b00, 4'b1111, 32'h0,  4'b0000, 2'b00, 1'b0, 32'h0,   32'h0,  4'b0011, 32'h77, 1'b0};
      tbl[12] = '{4'b0000, 2'b00, 4'b1111, 32'h0,  4'b0000, 2'b00, 1'b0, 32'h0,   32'h0,  4'b0000, 32'h0,  1'b1};

      // Outputs during reset, with requests present and then absent
      rst = 1'b0;
      model_reset();
      fixed_addrs();
      mem_rdata = 32'h0;
      ld_data_ready = '1;
      ld_valid = '1;
      st_valid = '1;
      @(negedge clk);
      chk("rst_ld_ready", 128'(ld_ready), 128'(0));
      chk("rst_st_ready", 128'(st_ready), 128'(0));
      chk("rst_mem_bus", 128'({mem_en, mem_we, mem_addr, mem_wdata}), 128'(0));
      chk("rst_ld_data_valid", 128'(ld_data_valid), 128'(0));
      chk("rst_ld_data", 128'(ld_data), 128'(0));
      ld_valid = '0;
      st_valid = '0;
      #1;
      chk("rst_idle", 128'(idle), 128'(1));
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Directed vectors from reset
      for (int r = 0; r < 13; r++) begin
         ld_valid = tbl[r].lv;
         st_valid = tbl[r].sv;
         ld_data_ready = tbl[r].ldr;
         mem_rdata = tbl[r].rdata;
         half();
         chk($sformatf("tbl%0d_ld_ready", r), 128'(ld_ready), 128'(tbl[r].e_lr));
         chk($sformatf("tbl%0d_st_ready", r), 128'(st_ready), 128'(tbl[r].e_sr));
         chk($sformatf("tbl%0d_mem_bus", r), 128'({mem_en, mem_we, mem_addr, mem_wdata}),
             128'({(tbl[r].e_lr != 0) || (tbl[r].e_sr != 0), tbl[r].e_we, tbl[r].e_addr, tbl[r].e_wdata}));
         chk($sformatf("tbl%0d_ld_data_valid", r), 128'(ld_data_valid), 128'(tbl[r].e_ldv));
         chk($sformatf("tbl%0d_idle", r), 128'(idle), 128'(tbl[r].e_idle));
         if (tbl[r].e_ldv[0]) chk($sformatf("tbl%0d_ld_data0", r), 128'(ld_data[DS-1:0]), 128'(tbl[r].e_d0));
         finish_cycle();
      end

      // Starvation: four ports keep loads eligible; store forced at cycles 4 and 9
      do_reset();
      ld_valid = '1;
      ld_data_ready = '1;
      st_valid = 2'b01;
      for (int c = 0; c < 10; c++) begin
         mem_rdata = $urandom;
         half();
         if (c == 4 || c == 9) begin
            chk($sformatf("starve_c%0d_ld_ready", c), 128'(ld_ready), 128'(0));
            chk($sformatf("starve_c%0d_st_ready", c), 128'({mem_we, st_ready}), 128'(3'b101));
         end else begin
            chk($sformatf("starve_c%0d_ld_ready", c), 128'(ld_ready), 128'(1 << (c < 4 ? c : c - 5)));
            chk($sformatf("starve_c%0d_we", c), 128'(mem_we), 128'(0));
         end
         finish_cycle();
      end

      // Backpressure on port 0 while port 1 keeps being served
      do_reset();
      ld_valid = 4'b0011;
      ld_data_ready = 4'b0010;
      c0 = 0; c1 = 0; held = '0; rd_c1 = '0; stable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         mem_rdata = $urandom;
         if (c == 1) rd_c1 = mem_rdata;
         half();
         if (ld_ready[0]) c0++;
         if (ld_ready[1]) c1++;
         if (c == 2) held = ld_data[DS-1:0];
         if (c > 2 && ld_data[DS-1:0] !== held) stable = 1'b0;
         finish_cycle();
      end
      chk("bp_port0_grants", 128'(c0), 128'(1));
      chk("bp_port1_grants", 128'(c1), 128'(3));
      chk("bp_data_value", 128'(held), 128'(rd_c1));
      chk("bp_data_stable", 128'(stable), 128'(1));
      chk("bp_slot_full", 128'(ld_data_valid[0]), 128'(1));

      // Reset in the cycle after a load grant discards the read
      do_reset();
      ld_valid = 4'b0001;
      ld_data_ready = '1;
      mem_rdata = 32'h0;
      step();
      rst = 1'b0;
      model_reset();
      st_valid = 2'b01;
      #2;
      chk("mid_rst_ld_ready", 128'(ld_ready), 128'(0));
      chk("mid_rst_st_ready", 128'(st_ready), 128'(0));
      chk("mid_rst_mem_bus", 128'({mem_en, mem_we, mem_addr, mem_wdata}), 128'(0));
      ld_valid = '0;
      st_valid = '0;
      #1;
      chk("mid_rst_idle", 128'(idle), 128'(1));
      @(posedge clk);
      #1;
      rst = 1'b1;
      mem_rdata = 32'hEE;
      for (int c = 0; c < 2; c++) begin
         half();
         chk($sformatf("post_rst%0d_ld_data_valid", c), 128'(ld_data_valid), 128'(0));
         chk($sformatf("post_rst%0d_idle", c), 128'(idle), 128'(1));
         finish_cycle();
      end

      // Randomized traffic against the model
      do_reset();
      for (int n = 0; n < 800; n++) begin
         ld_valid = LC'($urandom);
         st_valid = ($urandom_range(0, 3) == 0) ? SC'($urandom) : '0;
         if (n >= 400) st_valid = SC'($urandom);
         ld_data_ready = LC'($urandom) | LC'($urandom);
         for (int i = 0; i < LC; i++) ld_addr[i*AS +: AS] = $urandom;
         for (int j = 0; j < SC; j++) begin
            st_addr[j*AS +: AS] = $urandom;
            st_data[j*DS +: DS] = $urandom;
         end
         mem_rdata = $urandom;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_scheduler.md
# mem_port_scheduler

Shares one single-port, one-cycle-latency memory between LOAD_COUNT load ports and STORE_COUNT store ports. Issues at most one memory access per cycle. Selection uses round-robin within each class and load-over-store priority between classes, with a starvation counter that forces a store grant. Sits between the elastic load/store operators and the on-chip memory, replacing the separate read and write arbiters when the memory has a single shared port.

## Interface
- LOAD_COUNT, 2: number of load ports (≥1)
- STORE_COUNT, 2: number of store ports (≥1)
- ADDRESS_SIZE, 32: address width
- DATA_SIZE, 32: data width
- STARVE_LIMIT, 4: cycles a store may be blocked by loads before it is forced (≥1, ≤255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- ld_valid  in  LOAD_COUNT  load address request per port
- ld_addr  in  LOAD_COUNT*ADDRESS_SIZE  packed addresses; port i at [i*ADDRESS_SIZE +: ADDRESS_SIZE]
- ld_ready  out  LOAD_COUNT  one-hot load grant; address accepted this cycle
- ld_data_valid  out  LOAD_COUNT  per-port response slot full
- ld_data  out  LOAD_COUNT*DATA_SIZE  per-port response slot contents
- ld_data_ready  in  LOAD_COUNT  consumer takes slot
- st_valid  in  STORE_COUNT  store request (address and data joined upstream)
- st_addr  in  STORE_COUNT*ADDRESS_SIZE  packed store addresses
- st_data  in  STORE_COUNT*DATA_SIZE  packed store data
- st_ready  out  STORE_COUNT  one-hot store grant
- mem_en  out  1  memory access this cycle
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDRESS_SIZE  access address (0 when mem_en=0)
- mem_wdata  out  DATA_SIZE  write data (0 when mem_we=0)
- mem_rdata  in  DATA_SIZE  read data, valid the cycle after a read
- idle  out  1  no request, no read in flight, all slots empty

## Operation
- A load port i is eligible when ld_valid[i]=1, slot i is empty at the start of the cycle, and port i has no read in flight. There is no same-cycle bypass of a draining slot.
- A store port j is eligible when st_valid[j]=1.
- Class choice per cycle:
  - If starve_cnt == STARVE_LIMIT and any store is eligible, the store class wins.
  - Else if any load is eligible, the load class wins.
  - Else if any store is eligible, the store class wins.
  - Else no grant.
- Within a class: rotating round-robin. Search starts at last_granted+1 modulo the class count. The pointer updates only when that class is granted. The pointer resets to the highest index, so port 0 wins first.
- starve_cnt (8 bit):
  - Resets to 0 and clears on any store grant.
  - Increments, saturating at STARVE_LIMIT, in cycles where a store is eligible but a load is granted.
  - Holds when no store is eligible.
- On a load grant to port i:
  - ld_ready[i]=1, mem_en=1, mem_we=0, mem_addr=ld_addr[i].
  - Set inflight[i].
  - Next cycle: capture mem_rdata into slot i, set ld_data_valid[i], clear inflight[i].
- On a store grant to port j: st_ready[j]=1, mem_en=1, mem_we=1, mem_addr=st_addr[j], mem_wdata=st_data[j]. A store completes in the grant cycle.
- Slot i clears when ld_data_valid[i] and ld_data_ready[i] are both 1. ld_data holds its value while the slot is full and no handshake has occurred.
- ld_ready, st_ready and the mem_* outputs are combinational from the request inputs and registered state.
- idle = no ld_valid, no st_valid, inflight==0 and ld_data_valid==0.

## Timing
- Load latency: address grant in cycle T; mem_rdata at T+1; ld_data_valid from T+2.
- The minimum interval between back-to-back loads on the same port is 3 cycles when the slot is drained immediately. Different ports can be granted loads on consecutive cycles.
- Store: accepted and written in the same cycle.
- Throughput: one access per cycle across all ports.
- A read and a write never occur in the same cycle.
- Reset (rst=0, asynchronous):
  - Clears slots, inflight, starve_cnt and pointers.
  - All outputs are 0 during reset; idle=1 if no requests are present.
  - A read in flight at reset is discarded, and mem_rdata is ignored in the first cycle after release.
- Simultaneous events:
  - A slot drain and a new grant to the same port in one cycle: the grant is not given; the port becomes eligible the following cycle.
  - A store grant and a slot capture in one cycle: both proceed.

## Test plan
- Single load: ld_valid=01, ld_addr[0]=0x10, mem_rdata=0xAB at T+1 -> ld_ready=01 at T; ld_data_valid=01 with ld_data[0]=0xAB from T+2 until ld_data_ready[0]=1.
- Load round-robin: ld_valid=11 held, ld_data_ready=11 -> grant order port0, port1, port0, …; no port is granted while its slot is full or its read is in flight.
- Starvation: ld_valid continuously eligible, st_valid=01 from cycle 0, STARVE_LIMIT=4 -> load grants in cycles 0–3, store grant (mem_we=1) in cycle 4, starve_cnt back to 0.
- Store round-robin: st_valid=11, no loads -> st_ready=01, 10, 01; mem_wdata equals the selected st_data each cycle.
- Backpressure: ld_data_ready[0]=0 for 10 cycles with ld_valid[0]=1 -> exactly one grant to port0; ld_data[0] stable; ld_valid[1] requests are still served.
- Reset mid-read: rst low in cycle T+1 after a load grant -> slot stays empty, ld_data_valid=0, idle=1 after release with no requests.
